// File: rtl/beat_packer.sv
// beat_packer: gathers PACK_FACTOR narrow input beats into one wide output word.
// Beat k of a word occupies lanes [k*DATA_WIDTH +: DATA_WIDTH], beat 0 in the LSBs.
// A word closes early when data_in_last is set. Unused upper lanes are zero, and
// data_out_count reports how many beats the word holds.
//
// Handshake (both sides): a transfer happens on a rising clk edge where valid and
// ready are both 1. A valid source holds its payload stable until that edge.
// data_in_ready never depends on data_in_valid. It does depend on data_in_last,
// because only a completing beat needs a free output register. Non-completing
// beats keep filling the accumulator while the output is stalled.
module beat_packer #(
    parameter int DATA_WIDTH  = 8,
    parameter int PACK_FACTOR = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [DATA_WIDTH-1:0]               data_in,
    input  logic                                data_in_valid,
    output logic                                data_in_ready,
    input  logic                                data_in_last,
    output logic [DATA_WIDTH*PACK_FACTOR-1:0]   data_out,
    output logic                                data_out_valid,
    input  logic                                data_out_ready,
    output logic                                data_out_last,
    output logic [$clog2(PACK_FACTOR):0]        data_out_count
);

    localparam int CNT_W   = $clog2(PACK_FACTOR);
    localparam int COUNT_W = $clog2(PACK_FACTOR) + 1;

    typedef logic [CNT_W-1:0]   cnt_t;
    typedef logic [COUNT_W-1:0] count_t;

    localparam cnt_t LAST_LANE = cnt_t'(PACK_FACTOR - 1);

    // Partial word: lanes 0..cnt-1 hold beats already accepted; higher lanes stay zero.
    logic [PACK_FACTOR-2:0][DATA_WIDTH-1:0] acc;
    cnt_t                                   cnt;

    logic                                   output_free;
    logic                                   accept;
    logic                                   completing;
    logic                                   out_xfer;
    logic [DATA_WIDTH*PACK_FACTOR-1:0]      next_word;

    assign output_free   = !data_out_valid || data_out_ready;
    assign data_in_ready = !rst && (output_free || (cnt != LAST_LANE && !data_in_last));
    assign accept        = data_in_valid && data_in_ready;
    assign completing    = accept && (cnt == LAST_LANE || data_in_last);
    assign out_xfer      = data_out_valid && data_out_ready;

    // Assemble the closing word: stored lanes below cnt, the incoming beat at cnt, zero above.
    always_comb begin
        next_word = '0;
        for (int k = 0; k < PACK_FACTOR - 1; k++) begin
            if (cnt_t'(k) < cnt) begin
                next_word[k*DATA_WIDTH +: DATA_WIDTH] = acc[k];
            end
        end
        for (int k = 0; k < PACK_FACTOR; k++) begin
            if (cnt_t'(k) == cnt) begin
                next_word[k*DATA_WIDTH +: DATA_WIDTH] = data_in;
            end
        end
    end

    // Accumulator and beat counter: store non-completing beats, restart after a completing one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
            cnt <= '0;
        end else if (completing) begin
            acc <= '0;
            cnt <= '0;
        end else if (accept) begin
            for (int k = 0; k < PACK_FACTOR - 1; k++) begin
                if (cnt_t'(k) == cnt) begin
                    acc[k] <= data_in;
                end
            end
            cnt <= cnt + cnt_t'(1);
        end
    end

    // Output register: load on a completing beat; otherwise drop valid once the word is taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out       <= '0;
            data_out_valid <= 1'b0;
            data_out_last  <= 1'b0;
            data_out_count <= '0;
        end else if (completing) begin
            data_out       <= next_word;
            data_out_valid <= 1'b1;
            data_out_last  <= data_in_last;
            data_out_count <= count_t'(cnt) + count_t'(1);
        end else if (out_xfer) begin
            data_out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_beat_packer.sv
// Directed bench for beat_packer at DATA_WIDTH=8, PACK_FACTOR=4.
// Inputs change just after each falling edge. Outputs are checked 1ns later,
// so every check sees the state left by the previous rising edge.
module tb_beat_packer;

    logic        clk;
    logic        rst;
    logic [7:0]  data_in;
    logic        data_in_valid;
    logic        data_in_ready;
    logic        data_in_last;
    logic [31:0] data_out;
    logic        data_out_valid;
    logic        data_out_ready;
    logic        data_out_last;
    logic [2:0]  data_out_count;

    int total = 0;
    int bad   = 0;

    beat_packer #(
        .DATA_WIDTH  (8),
        .PACK_FACTOR (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .data_in        (data_in),
        .data_in_valid  (data_in_valid),
        .data_in_ready  (data_in_ready),
        .data_in_last   (data_in_last),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .data_out_ready (data_out_ready),
        .data_out_last  (data_out_last),
        .data_out_count (data_out_count)
    );

    // Clock: 10ns period, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: count it, and report the tag with observed and expected values on failure.
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Apply one cycle of inputs just after a falling edge, then let them settle.
    task automatic drive(input logic v, input logic [7:0] d, input logic l, input logic ordy);
        @(negedge clk);
        data_in_valid  = v;
        data_in        = d;
        data_in_last   = l;
        data_out_ready = ordy;
        #1;
    endtask

    // Check the whole output register at once.
    task automatic chk_out(input string tag, input logic [31:0] w, input logic v,
                           input logic [2:0] c, input logic l);
        chk({tag, ".data"},  64'(data_out),       64'(w));
        chk({tag, ".valid"}, 64'(data_out_valid), 64'(v));
        chk({tag, ".count"}, 64'(data_out_count), 64'(c));
        chk({tag, ".last"},  64'(data_out_last),  64'(l));
    endtask

    initial begin
        rst            = 1'b1;
        data_in        = 8'h00;
        data_in_valid  = 1'b0;
        data_in_last   = 1'b0;
        data_out_ready = 1'b0;

        // Reset state
        #2;
        chk_out("reset", 32'h0, 1'b0, 3'd0, 1'b0);
        chk("reset.in_ready", 64'(data_in_ready), 64'(0));
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        rst = 1'b0;
        #1;
        chk("idle.in_ready", 64'(data_in_ready), 64'(1));

        // Four full beats back to back: one word, valid for exactly one cycle
        drive(1'b1, 8'h11, 1'b0, 1'b1);
        chk("full.b0_ready", 64'(data_in_ready), 64'(1));
        drive(1'b1, 8'h22, 1'b0, 1'b1);
        drive(1'b1, 8'h33, 1'b0, 1'b1);
        chk("full.not_yet", 64'(data_out_valid), 64'(0));
        drive(1'b1, 8'h44, 1'b0, 1'b1);
        chk("full.b3_ready", 64'(data_in_ready), 64'(1));
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        chk_out("full.word", 32'h44332211, 1'b1, 3'd4, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        chk("full.one_cycle", 64'(data_out_valid), 64'(0));
        chk("full.held", 64'(data_out), 64'(32'h44332211));

        // Short packet: two beats closed by last
        drive(1'b1, 8'hAA, 1'b0, 1'b1);
        drive(1'b1, 8'hBB, 1'b1, 1'b1);
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        chk_out("short", 32'h0000BBAA, 1'b1, 3'd2, 1'b1);
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        chk("short.drop", 64'(data_out_valid), 64'(0));

        // Lone beat with last becomes W1, then is held while the next word fills
        drive(1'b1, 8'h7F, 1'b1, 1'b0);
        chk("lone.ready", 64'(data_in_ready), 64'(1));
        drive(1'b1, 8'h55, 1'b0, 1'b0);
        chk_out("lone", 32'h0000007F, 1'b1, 3'd1, 1'b1);
        chk("stall.b0_ready", 64'(data_in_ready), 64'(1));
        drive(1'b1, 8'h66, 1'b0, 1'b0);
        chk("stall.b1_ready", 64'(data_in_ready), 64'(1));
        drive(1'b1, 8'h77, 1'b0, 1'b0);
        chk("stall.b2_ready", 64'(data_in_ready), 64'(1));
        drive(1'b1, 8'h88, 1'b0, 1'b0);
        chk("stall.b3_blocked", 64'(data_in_ready), 64'(0));
        drive(1'b1, 8'h88, 1'b0, 1'b0);
        chk("stall.b3_still_blocked", 64'(data_in_ready), 64'(0));
        chk_out("stall.w1_stable", 32'h0000007F, 1'b1, 3'd1, 1'b1);
        drive(1'b1, 8'h88, 1'b0, 1'b1);
        chk("stall.b3_released", 64'(data_in_ready), 64'(1));
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        chk_out("stall.w2", 32'h88776655, 1'b1, 3'd4, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        chk("stall.drained", 64'(data_out_valid), 64'(0));

        // Asynchronous reset mid-word, with a word waiting in the output
        drive(1'b1, 8'h3C, 1'b1, 1'b0);
        drive(1'b1, 8'hA1, 1'b0, 1'b0);
        drive(1'b1, 8'hA2, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        chk_out("pre_rst", 32'h0000003C, 1'b1, 3'd1, 1'b1);
        #1 rst = 1'b1;
        #1;
        chk_out("async_rst", 32'h0, 1'b0, 3'd0, 1'b0);
        chk("async_rst.in_ready", 64'(data_in_ready), 64'(0));
        #1 rst = 1'b0;
        drive(1'b1, 8'h01, 1'b0, 1'b1);
        drive(1'b1, 8'h02, 1'b0, 1'b1);
        drive(1'b1, 8'h03, 1'b0, 1'b1);
        drive(1'b1, 8'h04, 1'b0, 1'b1);
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        chk_out("post_rst", 32'h04030201, 1'b1, 3'd4, 1'b0);

        // Last on the 4th beat, then the next word starts again at lane 0
        drive(1'b1, 8'hC1, 1'b0, 1'b1);
        drive(1'b1, 8'hC2, 1'b0, 1'b1);
        drive(1'b1, 8'hC3, 1'b0, 1'b1);
        drive(1'b1, 8'hC4, 1'b1, 1'b1);
        drive(1'b1, 8'hD1, 1'b0, 1'b1);
        chk_out("last4", 32'hC4C3C2C1, 1'b1, 3'd4, 1'b1);
        drive(1'b1, 8'hD2, 1'b1, 1'b1);
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        chk_out("after_last4", 32'h0000D2D1, 1'b1, 3'd2, 1'b1);

        drive(1'b0, 8'h00, 1'b0, 1'b1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
